// File: rtl/mult_share_pkg.sv
// Shared constants for the multiplier-sharing scheduler.
//   OP_W      operand width of the shared multiplier
//   PROD_W    product width
//   N_REQ_DEF default number of requesters
//   id_w(n)   requester tag width, never narrower than one bit
package mult_share_pkg;
    localparam int OP_W      = 32'sd8;
    localparam int PROD_W    = 32'sd16;
    localparam int N_REQ_DEF = 32'sd4;

    function automatic int id_w(input int n);
        if (n <= 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction
endpackage

// File: rtl/Wallace_8X8.sv
// Shared combinational unsigned 8x8 multiplier.
//   X, Y  operands
//   P     exact 16-bit product
module Wallace_8X8 (
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
    output logic [15:0] P
);
    assign P = 16'(X) * 16'(Y);
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal rotating pointer.
//   req     request vector
//   en      grant enable; the pointer only moves on an enabled, non-empty request
//   gnt     one-hot grant (zero when disabled or no request)
//   gnt_id  encoded index of the winner (valid while gnt is non-zero)
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int N    = N_REQ_DEF,
    parameter int ID_W = id_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);
    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] ptr_nxt_s;
    logic [ID_W-1:0] win_s;
    logic [ID_W-1:0] idx_s;
    logic            found_s;
    int              idx_i;

    // Search upward from the pointer with wrap-around; first active request wins.
    always_comb begin
        found_s   = 1'b0;
        win_s     = '0;
        idx_s     = '0;
        idx_i     = 32'sd0;
        gnt       = '0;
        ptr_nxt_s = '0;
        for (int k = 0; k < N; k++) begin
            idx_i = int'(ptr_r) + k;
            if (idx_i >= N) begin
                idx_i = idx_i - N;
            end else begin
                idx_i = idx_i;
            end
            idx_s = ID_W'(idx_i);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        if (en && found_s) begin
            gnt[win_s] = 1'b1;
        end else begin
            gnt = '0;
        end
        if (int'(win_s) == N - 1) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = win_s + ID_W'(1);
        end
        gnt_id = win_s;
    end

    // Pointer moves just past the winner on every accepted grant, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (en && found_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one Wallace_8X8 multiplier among N_REQ
// requesters through a two-stage (operand / product) pipeline with backpressure.
//   req_valid/req_ready  per-requester handshake, req_x/req_y packed 8-bit operands
//   rsp_valid/rsp_ready  response handshake, rsp_data product, rsp_id requester tag
//   busy                 either pipeline stage holds a valid entry
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*8-1:0]    req_x,
    input  logic [N_REQ*8-1:0]    req_y,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    output logic [PROD_W-1:0]     rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy
);
    logic              s1_v_r, s2_v_r;
    logic [OP_W-1:0]   s1_x_r, s1_y_r;
    logic [ID_W-1:0]   s1_id_r, s2_id_r;
    logic [PROD_W-1:0] s2_p_r;
    logic              s1_adv_s, s2_adv_s, arb_en_s, grant_s;
    logic [N_REQ-1:0]  gnt_s;
    logic [ID_W-1:0]   gnt_id_s;
    logic [PROD_W-1:0] prod_s;
    logic [OP_W-1:0]   x_arr_s [N_REQ];
    logic [OP_W-1:0]   y_arr_s [N_REQ];

    assign s2_adv_s = !s2_v_r || rsp_ready;
    assign s1_adv_s = !s1_v_r || s2_adv_s;
    // Gating with rst_n keeps req_ready low while reset is held.
    assign arb_en_s = s1_adv_s && rst_n;
    assign grant_s  = |gnt_s;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign x_arr_s[g] = req_x[g*8 +: 8];
        assign y_arr_s[g] = req_y[g*8 +: 8];
    end

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .en     (arb_en_s),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s)
    );

    Wallace_8X8 u_mult (
        .X (s1_x_r),
        .Y (s1_y_r),
        .P (prod_s)
    );

    // Operand stage: capture the winner when it can advance, else empty or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r  <= 1'b0;
            s1_x_r  <= '0;
            s1_y_r  <= '0;
            s1_id_r <= '0;
        end else if (s1_adv_s) begin
            s1_v_r <= grant_s;
            if (grant_s) begin
                s1_x_r  <= x_arr_s[gnt_id_s];
                s1_y_r  <= y_arr_s[gnt_id_s];
                s1_id_r <= gnt_id_s;
            end else begin
                s1_id_r <= s1_id_r;
            end
        end else begin
            s1_v_r <= s1_v_r;
        end
    end

    // Product stage: registered multiplier result feeding the response port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r  <= 1'b0;
            s2_p_r  <= '0;
            s2_id_r <= '0;
        end else if (s2_adv_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                s2_p_r  <= prod_s;
                s2_id_r <= s1_id_r;
            end else begin
                s2_id_r <= s2_id_r;
            end
        end else begin
            s2_v_r <= s2_v_r;
        end
    end

    assign req_ready = gnt_s;
    assign rsp_valid = s2_v_r;
    assign rsp_data  = s2_p_r;
    assign rsp_id    = s2_id_r;
    assign busy      = s1_v_r || s2_v_r;
endmodule

// File: tb/tb_mult_share_sched.sv
module tb_mult_share_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [31:0] req_x = 32'h0;
    logic [31:0] req_y = 32'h0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready = 1'b0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mult_share_sched #(.N_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reset with all requesters asserting; outputs must stay quiet throughout.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rsp_ready = 1'b0; req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_req_ready2", 32'(req_ready), 32'h0);
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rr_x(input int i); return 8'(i + 3); endfunction
    function automatic logic [7:0] rr_y(input int i); return 8'(17 * i + 5); endfunction
    function automatic logic [15:0] rr_p(input int i); return 16'(rr_x(i)) * 16'(rr_y(i)); endfunction

    typedef struct {
        int          id;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        logic [15:0] p;
        int          id;
        int          e;
    } ent_t;

    initial begin
        vec_t        vecs [6];
        ent_t        q [$];
        logic [3:0]  bp_rdy [8];
        logic        bp_rv  [8];
        int          bp_id  [8];
        logic        pend [4];
        logic [7:0]  px [4];
        logic [7:0]  py [4];
        int          ptr_m, ec, cnt, g, idx;
        logic        vis, can;

        vecs[0] = '{2, 8'h0D, 8'h0B, 16'h008F};
        vecs[1] = '{0, 8'h00, 8'hFF, 16'h0000};
        vecs[2] = '{1, 8'hFF, 8'hFF, 16'hFE01};
        vecs[3] = '{3, 8'h80, 8'h02, 16'h0100};
        vecs[4] = '{1, 8'hFF, 8'h01, 16'h00FF};
        vecs[5] = '{0, 8'h07, 8'h09, 16'h003F};

        bp_rdy = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h1};
        bp_rv  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        bp_id  = '{0, 0, 0, 0, 0, 0, 1, 2};

        do_reset();

        // Single-requester vectors, including corner operands.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            req_valid = 4'(1 << vecs[v].id);
            req_x[vecs[v].id*8 +: 8] = vecs[v].x;
            req_y[vecs[v].id*8 +: 8] = vecs[v].y;
            @(negedge clk);
            chk("vec_ready", 32'(req_ready), 32'(1 << vecs[v].id));
            @(posedge clk); #1;
            req_valid = 4'h0;
            chk("vec_lat_early", 32'(rsp_valid), 32'h0);
            @(posedge clk); #1;
            chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].p));
            chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
        end
        @(posedge clk); #1;

        // All four requesting continuously from pointer 0.
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            req_x[i*8 +: 8] = rr_x(i);
            req_y[i*8 +: 8] = rr_y(i);
        end
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
            chk("rr_rsp_valid", 32'(rsp_valid), (c >= 2) ? 32'h1 : 32'h0);
            if (c >= 2) begin
                chk("rr_rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
                chk("rr_rsp_data", 32'(rsp_data), 32'(rr_p((c - 2) % 4)));
            end
            @(posedge clk); #1;
        end

        // Backpressure for five cycles, then release.
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'hF; rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'(bp_rdy[c]));
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(bp_rv[c]));
            if (bp_rv[c]) begin
                chk("bp_rsp_id", 32'(rsp_id), 32'(bp_id[c]));
                chk("bp_rsp_data", 32'(rsp_data), 32'(rr_p(bp_id[c])));
            end
            @(posedge clk); #1;
            if (c == 4) rsp_ready = 1'b1;
        end

        // Reset mid-stream with both stages full.
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_full_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_req_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b0110; rsp_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        chk("mid_first_grant", 32'(req_ready), 32'h2);
        chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        req_valid = 4'h0;
        chk("mid_no_rsp2", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        chk("mid_after_valid", 32'(rsp_valid), 32'h1);
        chk("mid_after_id", 32'(rsp_id), 32'h1);
        chk("mid_after_data", 32'(rsp_data), 32'(rr_p(1)));

        // Randomized traffic against a queue-based reference.
        do_reset();
        @(posedge clk); #1;
        ptr_m = 0; ec = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0; px[i] = 8'h0; py[i] = 8'h0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(2, 0) != 0) begin
                    pend[i] = 1'b1;
                    px[i] = ($urandom_range(9, 0) == 0) ? 8'hFF : 8'($urandom);
                    py[i] = ($urandom_range(9, 0) == 0) ? 8'hFF : 8'($urandom);
                end
                req_valid[i] = pend[i];
                req_x[i*8 +: 8] = px[i];
                req_y[i*8 +: 8] = py[i];
            end
            rsp_ready = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            cnt = q.size();
            vis = (cnt > 0) && (q[0].e + 2 <= ec);
            can = (cnt < 2) || rsp_ready;
            g = -1;
            if (can) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (ptr_m + k) % 4;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            chk("rnd_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'h0);
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(vis));
            chk("rnd_busy", 32'(busy), 32'(cnt > 0));
            if (vis) begin
                chk("rnd_rsp_data", 32'(rsp_data), 32'(q[0].p));
                chk("rnd_rsp_id", 32'(rsp_id), 32'(q[0].id));
            end
            @(posedge clk);
            if (vis && rsp_ready) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{16'(px[g]) * 16'(py[g]), g, ec});
                pend[g] = 1'b0;
                ptr_m = (g + 1) % 4;
            end
            ec++;
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Round-robin scheduler that shares one combinational `Wallace_8X8` multiplier between `N_REQ` requesters. Each requester has a valid/ready port, and each accepted operand pair returns one tagged 16-bit product. Operands are registered in front of the multiplier and the product is registered behind it, giving a two-stage pipeline with full backpressure. The block sits between requesting engines and the single shared multiplier instance.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 1..16.
- `ID_W`, default `$clog2(N_REQ)` with a minimum of 1: width of the requester tag.
- `clk`  in  1  single clock for the block; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_x`  in  N_REQ*8  multiplicand; requester i uses bits [8i+7:8i].
- `req_y`  in  N_REQ*8  multiplier; requester i uses bits [8i+7:8i].
- `req_ready`  out  N_REQ  one-hot or zero; high = requester i is granted this cycle.
- `rsp_valid`  out  1  product available.
- `rsp_data`  out  16  unsigned product X*Y.
- `rsp_id`  out  ID_W  index of the requester that issued the operands.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high while either pipeline stage holds a valid entry.

## Operation
- **Handshake.** A transfer on requester i occurs when `req_valid[i]` and `req_ready[i]` are both high at a clock edge. The response transfers when `rsp_valid` and `rsp_ready` are both high.
- **Requester rules.** Hold `req_valid`, `req_x` and `req_y` stable until accepted. `req_valid` must not depend on `req_ready`.
- **Ready path.** `req_ready` is combinational from `req_valid`, the pointer and pipeline state.
- **Stage S1** holds `s1_v`, `s1_x`, `s1_y` and `s1_id`. It feeds `Wallace_8X8` combinationally (X = `s1_x`, Y = `s1_y`).
- **Stage S2** holds `s2_v`, `s2_p[15:0]` and `s2_id`. It drives `rsp_valid`, `rsp_data` and `rsp_id` directly from flops.
- **Advance conditions:**
  - `s2_adv = !s2_v | rsp_ready`.
  - `s1_adv = !s1_v | s2_adv`.
  - Grant is allowed only when `s1_adv` is high.
- **Arbitration.** Round-robin, searching from pointer `ptr` upward with wrap-around. The first `i` with `req_valid[i]` high wins.
- **Pointer update.** On an accepted grant to `i`, `ptr` becomes `(i+1) mod N_REQ`. With no grant, `ptr` holds.
- **S1 load on each edge where `s1_adv`:**
  - On a grant: `s1_v` = 1 and the winner's operands and id are captured.
  - Otherwise `s1_v` = 0.
- **S2 load on each edge where `s2_adv`:** `s2_v` = `s1_v`. Product and id are captured when `s1_v` is high.
- **Arithmetic.** Unsigned 8x8 to 16 bits, exact, no truncation. 255*255 = 0xFE01.
- **`busy`** = `s1_v | s2_v`.
- **Reset values:**
  - `req_ready` and `rsp_valid` = 0 (`req_ready` may rise combinationally once `rst_n` is released).
  - `rsp_data`, `rsp_id` and all stage data = 0.
  - `ptr` = 0.
  - `busy` = 0.

## Timing
- **Latency.** Operands accepted at edge k appear on `rsp_*` after edge k+1, i.e. `rsp_valid` is high in cycle k+1 (one cycle after acceptance).
- **Throughput.** One product per cycle while `rsp_ready` stays high.
- **Stall.** With `rsp_ready` low and both stages full:
  - `req_ready` = 0.
  - Both stages and `ptr` hold.
  - `rsp_*` stay stable.
- **Stall release.** When `rsp_ready` rises, S2 drains, S1 moves up, and a new grant is issued in the same cycle (no bubble).
- **Single-bubble case.** With only S2 full and stalled, S1 can still accept one entry. After that, `req_ready` drops.
- **Simultaneous requests.** Every active requester is served once within N_REQ grants (starvation-free).
- **`N_REQ` = 1.** The pointer is constant and `req_ready[0]` = `req_valid[0] & s1_adv`.
- **Reset mid-operation.** Asserting `rst_n` low clears all state asynchronously. In-flight products are dropped, and no response is emitted after release.

## Structure
- **Package `mult_share_pkg`:**
  - `OP_W` = 8.
  - `PROD_W` = 16.
  - Default `N_REQ`.
  - A function `id_w(n)` returning max(1, clog2(n)).
- **Sub-module `rr_arbiter`** (parameter `N`):
  - Inputs: `req`, `en`.
  - Outputs: one-hot `gnt` and its encoded `gnt_id`.
  - Owns the `ptr` register and updates it only when `en & |req`.
- **Top:** pipeline registers, operand mux, and one unmodified `Wallace_8X8` instance.

## Test plan
- **Single requester.** Requester 2 sends X=0x0D, Y=0x0B with `rsp_ready` = 1 → `rsp_valid` one cycle after acceptance, `rsp_data` = 0x008F, `rsp_id` = 2.
- **All four requesting continuously**, pointer starting at 0 → grant order 0,1,2,3,0,… with one response per cycle and ids in the same order.
- **Backpressure.** Hold `rsp_ready` = 0 for 5 cycles with all requesting:
  - Exactly two entries are accepted, then `req_ready` = 0.
  - `rsp_*` stay stable.
  - After release, no loss or duplication, and the order is preserved.
- **Corner operands** X/Y = 0x00/0xFF, 0xFF/0xFF, 0x80/0x02 → 0x0000, 0xFE01, 0x0100. Plus 10k random pairs checked against a reference product.
- **Reset mid-stream.** Pull `rst_n` low with both stages full → `rsp_valid`, `busy` and `req_ready` go to 0 immediately. After release, `ptr` restarts at 0 and the first grant goes to the lowest active index.
